// File: rtl/spi_burst_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_burst_slave
// Description : SPI slave front-end bridging a serial master to a register
//               bank, with auto-incrementing read/write bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_burst_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int ADDR_INC   = 1
) (
    input  logic                  SCLK,
    input  logic                  RST,
    input  logic                  SS,
    input  logic                  MOSI,
    input  logic [DATA_WIDTH-1:0] Rd_Data,
    output logic                  MISO,
    output logic                  MISO_OE,
    output logic                  Wr_EN,
    output logic                  Rd_EN,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] Wr_Data,
    output logic                  Busy,
    output logic [CNT_WIDTH-1:0]  Word_Cnt,
    output logic                  Frame_Err
);

    localparam int c_max_w = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int c_bit_w = $clog2(c_max_w);

    localparam logic [c_bit_w-1:0]    c_addr_last = c_bit_w'(ADDR_WIDTH - 1);
    localparam logic [c_bit_w-1:0]    c_data_last = c_bit_w'(DATA_WIDTH - 1);
    localparam logic [c_bit_w-1:0]    c_one       = c_bit_w'(1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_step = ADDR_WIDTH'(ADDR_INC);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_opcode = 3'd1;
    localparam logic [2:0] c_st_addr   = 3'd2;
    localparam logic [2:0] c_st_wdata  = 3'd3;
    localparam logic [2:0] c_st_rdata  = 3'd4;

    logic [2:0]            r_state;
    logic                  r_rw;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [ADDR_WIDTH-2:0] r_addr_sr;
    logic [DATA_WIDTH-2:0] r_shift;
    logic [ADDR_WIDTH-1:0] r_next_addr;

    logic [ADDR_WIDTH-1:0] w_addr_full;
    logic [DATA_WIDTH-1:0] w_word_full;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;

    assign w_addr_full = {r_addr_sr, MOSI};
    assign w_word_full = {r_shift, MOSI};
    assign w_cnt_inc   = (Word_Cnt == {CNT_WIDTH{1'b1}}) ? Word_Cnt : Word_Cnt + 1'b1;

    always_ff @(posedge SCLK) begin
        if (!RST) begin
            r_state     <= c_st_idle;
            r_rw        <= 1'b0;
            r_bit_cnt   <= '0;
            r_addr_sr   <= '0;
            r_shift     <= '0;
            r_next_addr <= '0;
            MISO        <= 1'b0;
            MISO_OE     <= 1'b0;
            Wr_EN       <= 1'b0;
            Rd_EN       <= 1'b0;
            Address     <= '0;
            Wr_Data     <= '0;
            Busy        <= 1'b0;
            Word_Cnt    <= '0;
            Frame_Err   <= 1'b0;
        end else begin
            Wr_EN     <= 1'b0;
            Rd_EN     <= 1'b0;
            Frame_Err <= 1'b0;
            if (SS) begin
                // A write word counts as partial once any of its bits has arrived
                if (r_state == c_st_opcode || r_state == c_st_addr ||
                    (r_state == c_st_wdata && r_bit_cnt != c_data_last))
                    Frame_Err <= 1'b1;
                r_state  <= c_st_idle;
                Busy     <= 1'b0;
                MISO     <= 1'b0;
                MISO_OE  <= 1'b0;
                Word_Cnt <= '0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (MOSI) begin
                            r_state <= c_st_opcode;
                            Busy    <= 1'b1;
                        end
                    end
                    c_st_opcode: begin
                        r_rw      <= MOSI;
                        r_bit_cnt <= c_addr_last;
                        r_state   <= c_st_addr;
                    end
                    c_st_addr: begin
                        r_addr_sr <= w_addr_full[ADDR_WIDTH-2:0];
                        if (r_bit_cnt == '0) begin
                            Address <= w_addr_full;
                            if (r_rw) begin
                                // Word 0 is requested now; the pointer moves on to word 1
                                r_next_addr <= w_addr_full + c_addr_step;
                                Rd_EN       <= 1'b1;
                                r_bit_cnt   <= '0;
                                r_state     <= c_st_rdata;
                            end else begin
                                r_next_addr <= w_addr_full;
                                r_bit_cnt   <= c_data_last;
                                r_state     <= c_st_wdata;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                        end
                    end
                    c_st_wdata: begin
                        r_shift <= w_word_full[DATA_WIDTH-2:0];
                        if (r_bit_cnt == '0) begin
                            Wr_Data     <= w_word_full;
                            Address     <= r_next_addr;
                            r_next_addr <= r_next_addr + c_addr_step;
                            Wr_EN       <= 1'b1;
                            Word_Cnt    <= w_cnt_inc;
                            r_bit_cnt   <= c_data_last;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                        end
                    end
                    c_st_rdata: begin
                        if (r_bit_cnt == '0) begin
                            r_shift   <= Rd_Data[DATA_WIDTH-2:0];
                            MISO      <= Rd_Data[DATA_WIDTH-1];
                            MISO_OE   <= 1'b1;
                            r_bit_cnt <= c_data_last;
                            // MISO_OE already set marks a reload, i.e. a word just finished
                            if (MISO_OE)
                                Word_Cnt <= w_cnt_inc;
                        end else begin
                            MISO      <= r_shift[DATA_WIDTH-2];
                            r_shift   <= r_shift << 1;
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                            if (r_bit_cnt == c_one) begin
                                Rd_EN       <= 1'b1;
                                Address     <= r_next_addr;
                                r_next_addr <= r_next_addr + c_addr_step;
                            end
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_burst_slave
// Description : Directed, table-driven self-checking bench for spi_burst_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_burst_slave;

    logic        sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Default configuration instance
    logic        rst_a, ss_a, mosi_a;
    logic [7:0]  rd_data_a;
    logic        miso_a, miso_oe_a, wr_en_a, rd_en_a, busy_a, ferr_a;
    logic [7:0]  addr_a, wr_data_a, cnt_a;

    // Wide, fixed-address instance
    logic        rst_b, ss_b, mosi_b;
    logic [15:0] rd_data_b;
    logic        miso_b, miso_oe_b, wr_en_b, rd_en_b, busy_b, ferr_b;
    logic [9:0]  addr_b;
    logic [15:0] wr_data_b;
    logic [7:0]  cnt_b;

    spi_burst_slave u_dut_a (
        .SCLK(sclk), .RST(rst_a), .SS(ss_a), .MOSI(mosi_a), .Rd_Data(rd_data_a),
        .MISO(miso_a), .MISO_OE(miso_oe_a), .Wr_EN(wr_en_a), .Rd_EN(rd_en_a),
        .Address(addr_a), .Wr_Data(wr_data_a), .Busy(busy_a), .Word_Cnt(cnt_a),
        .Frame_Err(ferr_a)
    );

    spi_burst_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .CNT_WIDTH(8), .ADDR_INC(0)) u_dut_b (
        .SCLK(sclk), .RST(rst_b), .SS(ss_b), .MOSI(mosi_b), .Rd_Data(rd_data_b),
        .MISO(miso_b), .MISO_OE(miso_oe_b), .Wr_EN(wr_en_b), .Rd_EN(rd_en_b),
        .Address(addr_b), .Wr_Data(wr_data_b), .Busy(busy_b), .Word_Cnt(cnt_b),
        .Frame_Err(ferr_b)
    );

    typedef struct {
        bit          rw;
        int          lead;
        logic [7:0]  addr;
        int          nwords;
        int          abort_bits;
        logic [23:0] d;
        logic [23:0] e;
        int          exp_cnt;
        int          exp_err;
    } vec_t;

    vec_t        vecs[8];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [15:0] rd_addr_q[$];
    logic [15:0] b_addr_q[$];
    logic [15:0] b_data_q[$];
    logic [23:0] rd_src;
    int          rd_idx;
    int          ferr_seen;
    int          both_seen = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // One clock edge, then capture strobes and serve read data
    task automatic tick();
        @(posedge sclk);
        #1;
        if (wr_en_a === 1'b1) begin
            wr_addr_q.push_back({8'h00, addr_a});
            wr_data_q.push_back({8'h00, wr_data_a});
        end
        if (rd_en_a === 1'b1) begin
            rd_addr_q.push_back({8'h00, addr_a});
            rd_data_a = (rd_idx < 3) ? rd_src[23 - 8*rd_idx -: 8] : 8'h00;
            rd_idx++;
        end
        if (wr_en_a === 1'b1 && rd_en_a === 1'b1) both_seen++;
        if (ferr_a === 1'b1) ferr_seen++;
        if (wr_en_b === 1'b1) begin
            b_addr_q.push_back({6'h00, addr_b});
            b_data_q.push_back(wr_data_b);
        end
    endtask

    task automatic send_header(input bit rw, input logic [7:0] addr);
        ss_a = 1'b0; mosi_a = 1'b1; tick();
        chk("busy_after_start", {31'd0, busy_a}, 32'd1);
        mosi_a = rw; tick();
        for (int i = 7; i >= 0; i--) begin
            mosi_a = addr[i]; tick();
        end
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        logic [23:0] got_miso;
        int          oe_low;
        logic [7:0]  part;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        rd_src = v.d; rd_idx = 0; ferr_seen = 0; got_miso = '0; oe_low = 0;
        ss_a = 1'b0;
        for (int i = 0; i < v.lead; i++) begin
            mosi_a = 1'b0; tick();
        end
        send_header(v.rw, v.addr);
        if (!v.rw) begin
            for (int w = 0; w < v.nwords; w++)
                for (int b = 7; b >= 0; b--) begin
                    mosi_a = v.d[23 - 8*w - (7 - b)]; tick();
                end
            part = (v.nwords < 3) ? v.d[23 - 8*v.nwords -: 8] : 8'h00;
            for (int b = 0; b < v.abort_bits; b++) begin
                mosi_a = part[7 - b]; tick();
            end
            mosi_a = (v.abort_bits < 8) ? part[7 - v.abort_bits] : 1'b0;
        end else begin
            mosi_a = 1'b0;
            for (int k = 0; k < v.nwords * 8; k++) begin
                tick();
                got_miso[23 - k] = miso_a;
                if (miso_oe_a !== 1'b1) oe_low++;
            end
        end
        chk($sformatf("v%0d_word_cnt", idx), cnt_a, v.exp_cnt);
        ss_a = 1'b1; tick();
        chk($sformatf("v%0d_busy_end", idx), {31'd0, busy_a}, 32'd0);
        chk($sformatf("v%0d_oe_miso_cnt_end", idx), {22'd0, miso_oe_a, miso_a, cnt_a}, 32'd0);
        tick();
        chk($sformatf("v%0d_frame_err_count", idx), ferr_seen, v.exp_err);
        chk($sformatf("v%0d_frame_err_clear", idx), {31'd0, ferr_a}, 32'd0);
        if (!v.rw) begin
            chk($sformatf("v%0d_wr_count", idx), wr_addr_q.size(), v.nwords);
            chk($sformatf("v%0d_rd_count", idx), rd_addr_q.size(), 0);
            for (int w = 0; w < v.nwords && w < wr_addr_q.size(); w++) begin
                chk($sformatf("v%0d_wr_addr%0d", idx, w), wr_addr_q[w], {8'h00, v.e[23 - 8*w -: 8]});
                chk($sformatf("v%0d_wr_data%0d", idx, w), wr_data_q[w], {8'h00, v.d[23 - 8*w -: 8]});
            end
        end else begin
            chk($sformatf("v%0d_wr_count", idx), wr_addr_q.size(), 0);
            // one extra prefetch is issued for the word after the last one shifted out
            chk($sformatf("v%0d_rd_count", idx), rd_addr_q.size(), v.nwords + 1);
            for (int w = 0; w < v.nwords && w < rd_addr_q.size(); w++)
                chk($sformatf("v%0d_rd_addr%0d", idx, w), rd_addr_q[w], {8'h00, v.e[23 - 8*w -: 8]});
            for (int w = 0; w < v.nwords; w++)
                chk($sformatf("v%0d_miso_word%0d", idx, w), got_miso[23 - 8*w -: 8], v.d[23 - 8*w -: 8]);
            chk($sformatf("v%0d_miso_oe_low", idx), oe_low, 0);
        end
    endtask

    initial begin
        //            rw lead addr  n  ab  data        exp addr    cnt err
        vecs[0] = '{1'b0, 0, 8'h35, 1, 0, 24'h1B0000, 24'h350000, 1, 0};
        vecs[1] = '{1'b0, 2, 8'hFE, 3, 0, 24'hCA521E, 24'hFEFF00, 3, 0};
        vecs[2] = '{1'b1, 0, 8'h35, 3, 0, 24'hDBCA52, 24'h353637, 2, 0};
        vecs[3] = '{1'b0, 0, 8'h10, 0, 3, 24'hA50000, 24'h000000, 0, 1};
        vecs[4] = '{1'b0, 1, 8'h80, 1, 0, 24'hFF0000, 24'h800000, 1, 0};
        vecs[5] = '{1'b1, 0, 8'hFF, 2, 0, 24'h018000, 24'hFF0000, 1, 0};
        vecs[6] = '{1'b0, 0, 8'h22, 1, 7, 24'h3CA500, 24'h220000, 1, 1};
        vecs[7] = '{1'b1, 0, 8'h7F, 1, 0, 24'h960000, 24'h7F0000, 0, 0};

        rst_a = 1'b0; ss_a = 1'b1; mosi_a = 1'b0; rd_data_a = 8'h00;
        rst_b = 1'b0; ss_b = 1'b1; mosi_b = 1'b0; rd_data_b = 16'h0000;
        rd_src = '0; rd_idx = 0; ferr_seen = 0;
        tick(); tick();
        chk("reset_a_outputs",
            {2'd0, miso_a, miso_oe_a, wr_en_a, rd_en_a, busy_a, ferr_a, addr_a, wr_data_a, cnt_a}, 32'd0);
        chk("reset_b_outputs",
            {busy_b, ferr_b, wr_en_b, rd_en_b, miso_b, miso_oe_b, addr_b, wr_data_b}, 32'd0);
        rst_a = 1'b1; rst_b = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_frame(i, vecs[i]);

        // SS raised in the middle of the address field
        ferr_seen = 0; wr_addr_q.delete();
        ss_a = 1'b0; mosi_a = 1'b1; tick();
        mosi_a = 1'b0; tick();
        mosi_a = 1'b1; tick(); tick(); tick();
        ss_a = 1'b1; tick();
        chk("addr_abort_busy", {31'd0, busy_a}, 32'd0);
        tick();
        chk("addr_abort_frame_err", ferr_seen, 1);
        chk("addr_abort_no_write", wr_addr_q.size(), 0);

        // Reset in the middle of a read burst
        rd_src = 24'h5AC300; rd_idx = 0; rd_addr_q.delete();
        send_header(1'b1, 8'h40);
        mosi_a = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        chk("mid_read_cnt_before_rst", cnt_a, 1);
        chk("mid_read_oe_before_rst", {31'd0, miso_oe_a}, 32'd1);
        rst_a = 1'b0; tick();
        chk("mid_read_rst_outputs",
            {2'd0, miso_a, miso_oe_a, wr_en_a, rd_en_a, busy_a, ferr_a, addr_a, wr_data_a, cnt_a}, 32'd0);
        ss_a = 1'b1; rst_a = 1'b1; tick();
        run_frame(8, vecs[0]);

        // Wide, fixed-address write burst
        ss_b = 1'b0; mosi_b = 1'b1; tick();
        mosi_b = 1'b0; tick();
        for (int i = 9; i >= 0; i--) begin
            mosi_b = ((10'h3A5 >> i) & 10'h1) != 10'h0; tick();
        end
        for (int i = 31; i >= 0; i--) begin
            mosi_b = ((32'hBEEF1234 >> i) & 32'h1) != 32'h0; tick();
        end
        chk("b_word_cnt", cnt_b, 2);
        ss_b = 1'b1; tick();
        chk("b_busy_end", {31'd0, busy_b}, 32'd0);
        chk("b_wr_count", b_addr_q.size(), 2);
        if (b_addr_q.size() >= 2) begin
            chk("b_wr_addr0", b_addr_q[0], 16'h03A5);
            chk("b_wr_addr1", b_addr_q[1], 16'h03A5);
            chk("b_wr_data0", b_data_q[0], 16'hBEEF);
            chk("b_wr_data1", b_data_q[1], 16'h1234);
        end

        chk("wr_rd_overlap", both_seen, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
